// File: rtl/spi_master_xfer_pkg.sv
// Shared SPI definitions: controller state encoding and shift-register modes
// reused by the peripheral-side receiver.
package spi_master_xfer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  typedef enum logic [1:0] {
    SH_HOLD  = 2'd0,
    SH_LEFT  = 2'd1,
    SH_RIGHT = 2'd2,
    SH_PLOAD = 2'd3
  } spi_shift_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_xfer_sclk_gen.sv
// SCLK generator: half-period counter plus SCLK register, with edge strobes
// for the shifter and a half-period strobe for SETUP/HOLD timing.
module spi_master_xfer_sclk_gen
  import spi_master_xfer_pkg::*;
#(
  parameter int unsigned CLKDIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_toggle_en,
  output logic o_sclk,
  output logic o_rise_tick_c,
  output logic o_fall_tick_c,
  output logic o_half_done_c
);

  localparam int unsigned CW = cnt_w(CLKDIV);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;

  assign o_half_done_c = i_en && (r_cnt == CW'(CLKDIV - 1));
  assign o_rise_tick_c = o_half_done_c && i_toggle_en && !r_sclk;
  assign o_fall_tick_c = o_half_done_c && i_toggle_en && r_sclk;
  assign o_sclk        = r_sclk;

  // Counter and SCLK both park at zero whenever the controller is idle.
  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_cnt <= o_half_done_c ? '0 : r_cnt + CW'(1);
      if (o_rise_tick_c)      r_sclk <= 1'b1;
      else if (o_fall_tick_c) r_sclk <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_master_xfer.sv
// SPI mode-0 initiator, MSB first. Define SPI_BURST_EN to chain words under
// one CS_N assertion when start is high on the edge that completes a word.
module spi_master_xfer
  import spi_master_xfer_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CLKDIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned BW = $clog2(WIDTH + 1);

  if (WIDTH < 2 || CLKDIV < 1) begin : g_bad_param
    $error("spi_master_xfer: WIDTH must be >= 2 and CLKDIV >= 1");
  end

  spi_state_e       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_rx_data;
  logic [BW-1:0]    r_bitcnt;
  logic             r_cs_n;
  logic             r_mosi;
  logic             r_busy;
  logic             r_done;

  logic w_gen_en;
  logic w_toggle_en;
  logic w_sclk;
  logic w_rise;
  logic w_fall;
  logic w_half_done;
  logic w_chain;

`ifdef SPI_BURST_EN
  assign w_chain = start;
`else
  assign w_chain = 1'b0;
`endif

  assign w_gen_en    = (r_state != ST_IDLE);
  assign w_toggle_en = (r_state == ST_XFER);

  spi_master_xfer_sclk_gen #(
    .CLKDIV(CLKDIV)
  ) u_sclk_gen (
    .clk          (clk),
    .reset        (reset),
    .i_en         (w_gen_en),
    .i_toggle_en  (w_toggle_en),
    .o_sclk       (w_sclk),
    .o_rise_tick_c(w_rise),
    .o_fall_tick_c(w_fall),
    .o_half_done_c(w_half_done)
  );

  // Transfer sequencing: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_rx_data <= '0;
      r_bitcnt  <= '0;
      r_cs_n    <= 1'b1;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shreg  <= tx_data;
            r_mosi   <= tx_data[WIDTH-1];
            r_cs_n   <= 1'b0;
            r_busy   <= 1'b1;
            r_bitcnt <= '0;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_half_done) r_state <= ST_XFER;
        end
        ST_XFER: begin
          if (w_rise) begin
            r_shreg  <= {r_shreg[WIDTH-2:0], miso};
            r_bitcnt <= r_bitcnt + BW'(1);
          end else if (w_fall) begin
            // The fall after the last sample ends the frame; MOSI keeps its bit.
            if (r_bitcnt == BW'(WIDTH)) r_state <= ST_HOLD;
            else                        r_mosi  <= r_shreg[WIDTH-1];
          end
        end
        ST_HOLD: begin
          if (w_half_done) begin
            r_rx_data <= r_shreg;
            r_done    <= 1'b1;
            if (w_chain) begin
              r_shreg  <= tx_data;
              r_mosi   <= tx_data[WIDTH-1];
              r_bitcnt <= '0;
              r_state  <= ST_XFER;
            end else begin
              r_cs_n  <= 1'b1;
              r_busy  <= 1'b0;
              r_mosi  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_data = r_rx_data;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sclk    = w_sclk;
  assign cs_n    = r_cs_n;
  assign mosi    = r_mosi;

endmodule
